// File: rtl/conv3x3_filter.sv
// 3x3 per-channel neighbourhood filter (pass / blur / sharpen / edge) on a vid_io stream.
// Build option: define CONV_BORDER_REPLICATE_EN to emit the unfiltered centre on border pixels.
module conv3x3_filter #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 1920,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_vid_data,
    input  logic                  i_vid_hsync,
    input  logic                  i_vid_vsync,
    input  logic                  i_vid_VDE,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_hsync,
    output logic                  o_vid_vsync,
    output logic                  o_vid_VDE,
    input  logic [3:0]            sw
);

    localparam int NCH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(H_ACTIVE - 1);

    logic [ADDR_WIDTH-1:0] col;
    logic                  col_full;
    logic [10:0]           row;
    logic                  vde_q;
    logic                  vs_q;
    logic [1:0]            mode;
    logic                  vs_rise;
    logic                  vde_fall;
    logic                  sw_unused;

    logic [DATA_WIDTH-1:0] rb0 [H_ACTIVE];
    logic [DATA_WIDTH-1:0] rb1 [H_ACTIVE];
    logic [DATA_WIDTH-1:0] rb0_rd;
    logic [DATA_WIDTH-1:0] rb1_rd;

    // win[r][c]: r=0 is row-2 (RB1), r=2 is the live row; c=2 is the newest column
    logic [DATA_WIDTH-1:0] win [3][3];
    logic                  border_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [DATA_WIDTH-1:0] filt;
    logic [DATA_WIDTH-1:0] border_val;
    logic [DATA_WIDTH-1:0] res;
    logic [1:0]            hs_d;
    logic [1:0]            vs_d;
    logic [1:0]            vde_d;

    assign sw_unused = ^sw[3:2];
    assign vs_rise   = i_vid_vsync & ~vs_q;
    assign vde_fall  = vde_q & ~i_vid_VDE;
    assign rb0_rd    = rb0[col];
    assign rb1_rd    = rb1[col];

    function automatic logic [7:0] clamp_u8(input logic signed [12:0] v);
        if (v < 13'sd0)
            return 8'd0;
        if (v > 13'sd255)
            return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [7:0] filt_chan(
        input logic [1:0] m,
        input logic [7:0] tl, input logic [7:0] tc, input logic [7:0] tr,
        input logic [7:0] ml, input logic [7:0] mc, input logic [7:0] mr,
        input logic [7:0] bl, input logic [7:0] bc, input logic [7:0] br
    );
        logic [11:0]        sum9;
        logic [23:0]        prod;
        logic signed [11:0] sharp;
        logic signed [12:0] edg;
        sum9  = 12'(tl) + 12'(tc) + 12'(tr) + 12'(ml) + 12'(mc) + 12'(mr)
              + 12'(bl) + 12'(bc) + 12'(br);
        prod  = 24'(sum9) * 24'd7282;
        sharp = $signed(12'd5 * 12'(mc) - 12'(tc) - 12'(bc) - 12'(ml) - 12'(mr));
        edg   = $signed({2'b00, mc, 3'b000} - (13'(sum9) - 13'(mc)));
        case (m)
            2'b01:   return 8'(prod >> 16);
            2'b10:   return clamp_u8({sharp[11], sharp});
            2'b11:   return clamp_u8(edg);
            default: return mc;
        endcase
    endfunction

    // Counters, edge detectors and mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            col_full <= 1'b0;
            row      <= '0;
            vde_q    <= 1'b0;
            vs_q     <= 1'b0;
            mode     <= 2'b00;
        end else begin
            vde_q <= i_vid_VDE;
            vs_q  <= i_vid_vsync;
            if (!i_vid_VDE) begin
                col      <= '0;
                col_full <= 1'b0;
            end else if (col == COL_LAST) begin
                col_full <= 1'b1;
            end else begin
                col <= col + ADDR_WIDTH'(1);
            end
            if (vs_rise)
                row <= '0;
            else if (vde_fall && row != 11'h7FF)
                row <= row + 11'd1;
            if (vs_rise)
                mode <= sw[1:0];
        end
    end

    // Row buffers keep their contents through reset; writes past the last column are dropped
    always_ff @(posedge clk) begin
        if (!rst && i_vid_VDE && !col_full) begin
            rb0[col] <= i_vid_data;
            rb1[col] <= rb0_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            border_q <= 1'b0;
            pix_q    <= '0;
        end else begin
            pix_q <= i_vid_data;
            if (i_vid_VDE) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 2; c++)
                        win[r][c] <= win[r][c+1];
                win[0][2] <= rb1_rd;
                win[1][2] <= rb0_rd;
                win[2][2] <= i_vid_data;
                border_q  <= (row < 11'd2) || (col < ADDR_WIDTH'(2));
            end
        end
    end

    always_comb begin
        filt = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            filt[8*ch +: 8] = filt_chan(mode,
                win[0][0][8*ch +: 8], win[0][1][8*ch +: 8], win[0][2][8*ch +: 8],
                win[1][0][8*ch +: 8], win[1][1][8*ch +: 8], win[1][2][8*ch +: 8],
                win[2][0][8*ch +: 8], win[2][1][8*ch +: 8], win[2][2][8*ch +: 8]);
        end
    end

`ifdef CONV_BORDER_REPLICATE_EN
    assign border_val = win[1][1];
`else
    assign border_val = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res         <= '0;
            hs_d        <= '0;
            vs_d        <= '0;
            vde_d       <= '0;
            o_vid_data  <= '0;
            o_vid_hsync <= 1'b0;
            o_vid_vsync <= 1'b0;
            o_vid_VDE   <= 1'b0;
        end else begin
            if (mode == 2'b00)
                res <= pix_q;
            else if (border_q)
                res <= border_val;
            else
                res <= filt;
            hs_d        <= {hs_d[0], i_vid_hsync};
            vs_d        <= {vs_d[0], i_vid_vsync};
            vde_d       <= {vde_d[0], i_vid_VDE};
            o_vid_hsync <= hs_d[1];
            o_vid_vsync <= vs_d[1];
            o_vid_VDE   <= vde_d[1];
            o_vid_data  <= vde_d[1] ? res : '0;
        end
    end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Scoreboard bench for conv3x3_filter: an image-based reference predicts every output cycle.
`timescale 1ns/1ps
module tb_conv3x3_filter;

    localparam int W     = 16;
    localparam int IMG_R = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] i_vid_data;
    logic        i_vid_hsync;
    logic        i_vid_vsync;
    logic        i_vid_VDE;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync;
    logic        o_vid_vsync;
    logic        o_vid_VDE;
    logic [3:0]  sw;

    always #5 clk = ~clk;

    conv3x3_filter #(.DATA_WIDTH(24), .H_ACTIVE(1920), .ADDR_WIDTH(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_vid_data  (i_vid_data),
        .i_vid_hsync (i_vid_hsync),
        .i_vid_vsync (i_vid_vsync),
        .i_vid_VDE   (i_vid_VDE),
        .o_vid_data  (o_vid_data),
        .o_vid_hsync (o_vid_hsync),
        .o_vid_vsync (o_vid_vsync),
        .o_vid_VDE   (o_vid_VDE),
        .sw          (sw)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        vde;
        logic        hs;
        logic        vs;
        logic        has_spot;
        logic [23:0] spot;
    } exp_t;

    typedef struct {
        int          r;
        int          c;
        logic [23:0] v;
    } spot_t;

    exp_t        sb[$];
    spot_t       spots[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    int          m_row, m_col, m_mode;
    logic        m_vde_prev, m_vs_prev;
    logic [23:0] img [IMG_R][W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int r, input int c, input int mode);
        logic [23:0] res;
        res = 24'h0;
        if (r < 2 || c < 2 || r >= IMG_R || c >= W)
            return 24'h0;
        for (int ch = 0; ch < 3; ch++) begin
            int p [3][3];
            int s, v, cc;
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    p[i][j] = int'(img[r-2+i][c-2+j][8*ch +: 8]);
                    s += p[i][j];
                end
            cc = p[1][1];
            case (mode)
                1:       v = (s * 7282) / 65536;
                2:       v = 5 * cc - p[0][1] - p[2][1] - p[1][0] - p[1][2];
                default: v = 8 * cc - (s - cc);
            endcase
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            res[8*ch +: 8] = 8'(v);
        end
        return res;
    endfunction

    task automatic tick(input logic vde, input logic hs, input logic vs, input logic [23:0] d);
        exp_t e;
        exp_t g;
        i_vid_VDE   = vde;
        i_vid_hsync = hs;
        i_vid_vsync = vs;
        i_vid_data  = d;
        e = '0;
        e.vde = vde;
        e.hs  = hs;
        e.vs  = vs;
        if (vde) begin
            if (m_row < IMG_R && m_col < W)
                img[m_row][m_col] = d;
            e.data = (m_mode == 0) ? d : ref_pix(m_row, m_col, m_mode);
            foreach (spots[k])
                if (spots[k].r == m_row && spots[k].c == m_col) begin
                    e.has_spot = 1'b1;
                    e.spot     = spots[k].v;
                end
        end
        sb.push_back(e);
        if (vde)
            m_col = (m_col < 1919) ? m_col + 1 : 1919;
        else
            m_col = 0;
        if (vs && !m_vs_prev) begin
            m_row  = 0;
            m_mode = int'(sw[1:0]);
        end else if (m_vde_prev && !vde && m_row < 2047) begin
            m_row++;
        end
        m_vde_prev = vde;
        m_vs_prev  = vs;
        @(posedge clk);
        @(negedge clk);
        g = sb.pop_front();
        check("data", 32'(o_vid_data), 32'(g.data));
        check("sync", 32'({o_vid_VDE, o_vid_hsync, o_vid_vsync}), 32'({g.vde, g.hs, g.vs}));
        if (g.has_spot)
            check("spot", 32'(o_vid_data), 32'(g.spot));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_data", 32'(o_vid_data), 32'h0);
        check("rst_sync", 32'({o_vid_VDE, o_vid_hsync, o_vid_vsync}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        sb.push_back(exp_t'(0));
        sb.push_back(exp_t'(0));
        m_row      = 0;
        m_col      = 0;
        m_mode     = 0;
        m_vde_prev = 1'b0;
        m_vs_prev  = 1'b0;
    endtask

    function automatic logic [23:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 24'h646464;
            1:       return 24'hFFFFFF;
            2:       return 24'h808080;
            3:       return (r == 3 && c == 5) ? 24'hFF0000 : 24'h000000;
            4:       return (r == 3 && c == 5) ? 24'hC8C8C8 : 24'h646464;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic vblank();
        for (int i = 0; i < 6; i++)
            tick(1'b0, 1'b0, (i >= 1 && i < 4), 24'h0);
    endtask

    task automatic hblank();
        for (int b = 0; b < 8; b++)
            tick(1'b0, (b >= 2 && b < 5), 1'b0, 24'h0);
    endtask

    task automatic send_frame(input int kind, input logic [1:0] sw_v, input logic [1:0] sw_mid,
                              input int rows, input bit gap);
        sw = {2'($urandom), sw_v};
        vblank();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 0)
                    sw = {sw[3:2], sw_mid};
                if (gap && r == rows - 1 && c == W / 2)
                    for (int g = 0; g < 10; g++)
                        tick(1'b0, 1'b0, 1'b0, 24'h0);
                tick(1'b1, 1'b0, 1'b0, pix(kind, r, c));
            end
            hblank();
        end
        spots.delete();
    endtask

    task automatic add_spot(input int r, input int c, input logic [23:0] v);
        spot_t s;
        s.r = r;
        s.c = c;
        s.v = v;
        spots.push_back(s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        i_vid_data  = '0;
        i_vid_hsync = 1'b0;
        i_vid_vsync = 1'b0;
        i_vid_VDE   = 1'b0;
        sw          = 4'b0000;
        for (int r = 0; r < IMG_R; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 24'h0;
        #1;
        do_reset();

        // pass mode, full-width ramp line, asynchronous reset mid-line
        sw = 4'b1100;
        vblank();
        for (int c = 0; c < 1920; c++) begin
            tick(1'b1, 1'b0, 1'b0, 24'(c & 255));
            if (c == 100)
                do_reset();
        end
        hblank();

        add_spot(4, 6, 24'h646464);
        add_spot(1, 6, 24'h000000);
        add_spot(4, 1, 24'h000000);
        send_frame(0, 2'b01, 2'b01, 6, 1'b0);

        add_spot(4, 6, 24'hFFFFFF);
        send_frame(1, 2'b01, 2'b01, 6, 1'b0);

        add_spot(4, 6, 24'h000000);
        send_frame(2, 2'b11, 2'b11, 6, 1'b0);

        add_spot(4, 6, 24'hFF0000);
        add_spot(4, 7, 24'h000000);
        add_spot(3, 6, 24'h000000);
        send_frame(3, 2'b11, 2'b11, 6, 1'b0);

        add_spot(4, 6, 24'hFFFFFF);
        add_spot(4, 7, 24'h000000);
        send_frame(4, 2'b10, 2'b10, 6, 1'b0);

        // sw changes to sharpen mid-frame; blur must persist until the next vsync
        add_spot(4, 6, 24'h6F6F6F);
        send_frame(4, 2'b01, 2'b10, 6, 1'b0);
        add_spot(4, 6, 24'hFFFFFF);
        send_frame(4, 2'b10, 2'b10, 6, 1'b0);

        send_frame(5, 2'b01, 2'b01, 5, 1'b0);
        send_frame(5, 2'b10, 2'b10, 5, 1'b0);
        send_frame(5, 2'b11, 2'b11, 5, 1'b1);
        send_frame(5, 2'b01, 2'b01, 5, 1'b1);
        send_frame(5, 2'b00, 2'b00, 4, 1'b1);

        for (int i = 0; i < 4; i++)
            tick(1'b0, 1'b0, 1'b0, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_filter.md
Name: conv3x3_filter

Overview:
- Downstream stage of the line-buffer front end. Consumes the vid_io pixel stream and applies a switch-selected 3x3 neighbourhood filter independently to each 8-bit channel: pass, box blur, sharpen or edge.
- Contains two internal row buffers and a 3x3 window, and emits a vid_io stream whose sync and VDE are delay-matched to the data.

Parameters:
- DATA_WIDTH, 24, pixel width; three 8-bit channels packed {red, blu, gre}.
- H_ACTIVE, 1920, active pixels per line; sets row-buffer depth.
- ADDR_WIDTH, 11, row-buffer address width; requires 2^ADDR_WIDTH >= H_ACTIVE.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_vid_data  in  DATA_WIDTH  input pixel.
- i_vid_hsync  in  1  input hsync.
- i_vid_vsync  in  1  input vsync.
- i_vid_VDE  in  1  input active-video flag.
- o_vid_data  out  DATA_WIDTH  filtered pixel (registered).
- o_vid_hsync  out  1  hsync delayed by LAT.
- o_vid_vsync  out  1  vsync delayed by LAT.
- o_vid_VDE  out  1  VDE delayed by LAT.
- sw  in  4  mode select; sw[1:0] used, sw[3:2] reserved and ignored.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst, clear immediately:
  - all outputs, col/row counters, window registers, delay pipes and the mode register to 0;
  - row-buffer contents are not cleared.
- Latency: LAT = 3 clocks, fixed for every mode. o_vid_hsync/vsync/VDE(t) = i_*(t-3) through a 3-deep shift register.
- Column counter (col):
  - increments on each clk with i_vid_VDE=1;
  - clears to 0 whenever i_vid_VDE=0;
  - saturates at H_ACTIVE-1; extra pixels are not written and reuse the last column.
- Row counter (row):
  - increments on each VDE 1->0 transition, saturating at 2047;
  - clears to 0 on vsync 0->1;
  - if both occur in the same cycle, the clear wins.
- Row buffers:
  - RB0 holds row r-1 and RB1 holds row r-2, both read-first at address col;
  - when VDE=1: RB0[col] <= i_vid_data and RB1[col] <= old RB0[col];
  - when VDE=0: no writes, and the window holds its contents.
- Window:
  - each VDE=1 cycle shifts the columns left;
  - the new right column is {RB1 out, RB0 out, input pixel};
  - the computed pixel is centred on input position (row-1, col-1), giving a one-pixel up/left shift.
- Mode register: loads sw[1:0] on vsync 0->1 only. It does not change mid-frame.
- Per-channel arithmetic, with c = centre, n/s/e/w = orthogonal neighbours, S = sum of all 9 pixels (12 bits):
  - 00 pass: output = input pixel delayed 3 clocks, with no border handling.
  - 01 blur: (S*7282)>>16, floor; S=2295 gives 255.
  - 10 sharpen: 5c - n - s - e - w, computed signed 12-bit and clamped to [0,255].
  - 11 edge: 8c - (S - c), computed signed 13-bit and clamped to [0,255].
- Border: in modes 01/10/11, output 0 when the window is incomplete (row<2 or col<2 at capture).
- o_vid_data is forced to 0 when the delayed VDE is 0.
- Reset mid-frame: the output is 0 until the pipeline refills. Borders are black for the first two rows after reset, even without a vsync.

Optional Feature:
- Macro: CONV_BORDER_REPLICATE_EN.
- Defined: border pixels in modes 01/10/11 output the window centre pixel unfiltered instead of 0.
- Undefined: border pixels are black (0). The pass mode is unaffected either way.

Test Plan:
- Reset with rst mid-line while VDE=1 -> all outputs 0 immediately (asynchronous); after release, o_vid_VDE follows i_vid_VDE by exactly 3 clocks.
- Mode 00, ramp data 0x000000..0x0000FF on a 1920-wide line -> o_vid_data equals the input 3 clocks later; hsync/vsync edges are also shifted by 3.
- Mode 01, flat frame 0x646464 -> interior pixels 0x646464; rows 0-1 and cols 0-1 are 0x000000.
- Mode 01, flat frame 0xFFFFFF -> interior 0xFFFFFF (no overflow).
- Mode 11 on flat 0x808080 -> interior 0x000000.
- Mode 11, single 0xFF pixel in red on a zero field -> centre output red 255 clamped; neighbours 0 after clamp.
- Mode 10, centre 200 with neighbours 100 -> 5*200 - 400 = 600, clamped to 255.
- Change sw from 01 to 10 mid-frame -> output stays blur until the next vsync rising edge, then switches to sharpen.
- VDE gap of 10 clocks inside a line -> window and buffers hold; output matches the same line streamed without the gap.
